// File: rtl/cpu_pkg.sv
// Shared CPU-front-end definitions: fetch FSM state encoding, NOP word, reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2
    } ifetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0340_0000;
    // PC register resets here so that the first next-PC is 32'h1C00_0000.
    localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry valid/ready instruction buffer between fetch and decode; flush empties it.
// IFETCH_ADEF_EN adds an exception flag stored alongside the instruction.
module ifetch_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_pc_i,
    input  logic [31:0]       fill_inst_i,
`ifdef IFETCH_ADEF_EN
    input  logic              fill_excp_i,
    output logic              excp_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o
);

    // Flush wins over a simultaneous fill; a fill wins over a consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            pc_o    <= '0;
            inst_o  <= '0;
`ifdef IFETCH_ADEF_EN
            excp_o  <= 1'b0;
`endif
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (fill_i) begin
            valid_o <= 1'b1;
            pc_o    <= fill_pc_i;
            inst_o  <= fill_inst_i;
`ifdef IFETCH_ADEF_EN
            excp_o  <= fill_excp_i;
`endif
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch request controller: one outstanding req/addr_ok/data_ok fetch, PC write on accept.
// IFETCH_ADEF_EN: misaligned next-PC raises ADEF (NOP into the buffer, no memory request).
module ifetch_ctrl #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] npc_i,
    output logic              pc_write_o,
    input  logic              flush_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [31:0]       inst_rdata_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [31:0]       id_inst_o
`ifdef IFETCH_ADEF_EN
    ,
    output logic              id_excp_o
`endif
);

    import cpu_pkg::*;

    ifetch_state_t     state;
    logic              cancel;
    logic [ADDR_W-1:0] req_pc;
    logic              can_issue;
    logic              misal;
    logic              cancel_next;
    logic              mem_fill;
    logic              adef_fill;
    logic [ADDR_W-1:0] addr_sel;

`ifdef IFETCH_ADEF_EN
    assign misal = |npc_i[1:0];
`else
    assign misal = 1'b0;
`endif

    assign can_issue   = (~id_valid_o | id_ready_i) & ~flush_i & ~rst;
    assign inst_req_o  = ((state == ST_IDLE) & can_issue & ~misal) | (state == ST_WAIT_ADDR);
    // A flush in the same cycle already counts as cancelling the outstanding fetch.
    assign cancel_next = cancel | (flush_i & (state != ST_IDLE));
    assign adef_fill   = (state == ST_IDLE) & can_issue & misal;
    assign mem_fill    = (state == ST_WAIT_DATA) & inst_data_ok_i & ~cancel_next;
    assign pc_write_o  = (inst_req_o & inst_addr_ok_i & ~cancel_next) | adef_fill;

    assign addr_sel = (state == ST_IDLE) ? npc_i : req_pc;
`ifdef IFETCH_ADEF_EN
    assign inst_addr_o = addr_sel;
`else
    assign inst_addr_o = {addr_sel[ADDR_W-1:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cancel <= 1'b0;
            req_pc <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_req_o) begin
                        req_pc <= npc_i;
                        state  <= inst_addr_ok_i ? ST_WAIT_DATA : ST_WAIT_ADDR;
                    end
                end
                ST_WAIT_ADDR: begin
                    if (flush_i) cancel <= 1'b1;
                    if (inst_addr_ok_i) state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (inst_data_ok_i) begin
                        cancel <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (flush_i) begin
                        cancel <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ifetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .fill_i      (mem_fill | adef_fill),
        .fill_pc_i   (mem_fill ? req_pc : npc_i),
        .fill_inst_i (mem_fill ? inst_rdata_i : NOP_INST),
`ifdef IFETCH_ADEF_EN
        .fill_excp_i (adef_fill),
        .excp_o      (id_excp_o),
`endif
        .ready_i     (id_ready_i),
        .valid_o     (id_valid_o),
        .pc_o        (id_pc_o),
        .inst_o      (id_inst_o)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl; covers the ADEF path when IFETCH_ADEF_EN is defined.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = '0;
    logic        pc_write;
    logic        flush = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef IFETCH_ADEF_EN
    logic        id_excp;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .npc_i          (npc),
        .pc_write_o     (pc_write),
        .flush_i        (flush),
        .inst_req_o     (req),
        .inst_addr_o    (addr),
        .inst_addr_ok_i (addr_ok),
        .inst_data_ok_i (data_ok),
        .inst_rdata_i   (rdata),
        .id_valid_o     (id_valid),
        .id_ready_i     (id_ready),
        .id_pc_o        (id_pc),
        .id_inst_o      (id_inst)
`ifdef IFETCH_ADEF_EN
        ,
        .id_excp_o      (id_excp)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        #1;
        chk("rst_req", req, 0);
        chk("rst_pcw", pc_write, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_inst", id_inst, 0);

        // First fetch: request, accept one cycle later, data the cycle after.
        cyc(); rst = 1'b0; npc = cpu_pkg::RESET_PC + 32'd4; #1;
        chk("a_req", req, 1);
        chk("a_addr", addr, 32'h1C00_0000);
        chk("a_pcw", pc_write, 0);
        cyc(); addr_ok = 1'b1; #1;
        chk("b_pcw", pc_write, 1);
        cyc(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678; #1;
        chk("c_req", req, 0);
        chk("c_pcw", pc_write, 0);
        chk("c_valid", id_valid, 0);

        // Second fetch: accept delayed three cycles while npc wanders.
        cyc(); data_ok = 1'b0; npc = 32'h1C00_0004; #1;
        chk("d_valid", id_valid, 1);
        chk("d_pc", id_pc, 32'h1C00_0000);
        chk("d_inst", id_inst, 32'h1234_5678);
        chk("d_req", req, 1);
        chk("d_addr", addr, 32'h1C00_0004);
        cyc(); npc = 32'h1C00_0040; #1;
        chk("e_addr", addr, 32'h1C00_0004);
        chk("e_req", req, 1);
        chk("e_valid", id_valid, 0);
        cyc(); npc = 32'h1C00_0080; #1;
        chk("f_addr", addr, 32'h1C00_0004);
        chk("f_pcw", pc_write, 0);
        cyc(); addr_ok = 1'b1; #1;
        chk("g_pcw", pc_write, 1);
        chk("g_addr", addr, 32'h1C00_0004);

        // Flush while waiting for data: data dropped, refetch from redirect target.
        cyc(); addr_ok = 1'b0; flush = 1'b1; npc = 32'h1C00_0100; #1;
        chk("h_req", req, 0);
        chk("h_pcw", pc_write, 0);
        cyc(); flush = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        chk("i_valid", id_valid, 0);
        cyc(); data_ok = 1'b0; #1;
        chk("j_valid", id_valid, 0);
        chk("j_req", req, 1);
        chk("j_addr", addr, 32'h1C00_0100);

        // Flush coincident with accept in WAIT_ADDR: no PC write, data discarded.
        cyc(); flush = 1'b1; addr_ok = 1'b1; npc = 32'h1C00_0200; #1;
        chk("k_req", req, 1);
        chk("k_addr", addr, 32'h1C00_0100);
        chk("k_pcw", pc_write, 0);
        cyc(); flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D; #1;
        chk("l_valid", id_valid, 0);
        cyc(); data_ok = 1'b0; addr_ok = 1'b1; #1;
        chk("m_valid", id_valid, 0);
        chk("m_req", req, 1);
        chk("m_addr", addr, 32'h1C00_0200);
        chk("m_pcw", pc_write, 1);

        // Decode stall with a full buffer for five cycles.
        cyc(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hA5A5_0001; id_ready = 1'b0; #1;
        cyc(); data_ok = 1'b0; npc = 32'h1C00_0204; #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin cyc(); #1; end
            chk("stall_req", req, 0);
            chk("stall_valid", id_valid, 1);
            chk("stall_pc", id_pc, 32'h1C00_0200);
            chk("stall_inst", id_inst, 32'hA5A5_0001);
        end
        cyc(); id_ready = 1'b1; addr_ok = 1'b1; #1;
        chk("rdy_req", req, 1);
        chk("rdy_addr", addr, 32'h1C00_0204);
        chk("rdy_pcw", pc_write, 1);

        // Flush in IDLE with a full buffer: buffer cleared, no request, resume next cycle.
        cyc(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_2222; id_ready = 1'b0; #1;
        chk("p_valid", id_valid, 0);
        cyc(); data_ok = 1'b0; flush = 1'b1; npc = 32'h1C00_0300; #1;
        chk("q_valid", id_valid, 1);
        chk("q_req", req, 0);
        chk("q_pcw", pc_write, 0);
        cyc(); flush = 1'b0; addr_ok = 1'b1; #1;
        chk("r_valid", id_valid, 0);
        chk("r_req", req, 1);
        chk("r_addr", addr, 32'h1C00_0300);
        chk("r_pcw", pc_write, 1);
        cyc(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2222_3333; id_ready = 1'b1; #1;

        // Misaligned next-PC.
        cyc(); data_ok = 1'b0; npc = 32'h1C00_0002; #1;
        chk("t_valid", id_valid, 1);
        chk("t_inst", id_inst, 32'h2222_3333);
`ifdef IFETCH_ADEF_EN
        chk("adef_req", req, 0);
        chk("adef_pcw", pc_write, 1);
        cyc(); id_ready = 1'b0; #1;
        chk("adef_valid", id_valid, 1);
        chk("adef_excp", id_excp, 1);
        chk("adef_inst", id_inst, 32'h0340_0000);
        chk("adef_pc", id_pc, 32'h1C00_0002);
        chk("adef_req2", req, 0);
`else
        chk("mis_req", req, 1);
        chk("mis_addr", addr, 32'h1C00_0000);
        chk("mis_pcw", pc_write, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
